// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared constants, FSM state type and the access legality
//               rule for the data-memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Width must be known, naturally aligned, and unsigned variants are loads only
  function automatic logic access_legal(input logic write,
                                        input logic [2:0] f3,
                                        input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00) & ~f3[2];
      default: ok = 1'b0;
    endcase
    if (write && f3[2]) ok = 1'b0;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Valid/ready data-memory bus between the access unit and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        valid;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, write, addr, wdata, wstrb,
                  input  ready, rdata);
  modport slave  (input  valid, write, addr, wdata, wstrb,
                  output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_load_extend
// Description : Selects the addressed byte/half lane of a read word and
//               sign- or zero-extends it according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] w_shifted;

  // Shift the addressed lane down to bit 0, then extend by access type
  always_comb begin
    w_shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  data = {24'h0, w_shifted[7:0]};
      F3_LHU:  data = {16'h0, w_shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access unit: strobe/lane generation,
//               load extension, pipeline stall, fault and timeout detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mem_request_type_in,
  input  logic               mem_request_write_in,
  input  logic [2:0]         funct3_in,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        store_data_in,
  input  logic               kill_in,
  output logic               stall_out,
  output logic [31:0]        load_data_out,
  output logic               load_valid_out,
  output logic               access_fault_out,
  output logic               timeout_out,
  mem_access_unit_if.master  dmem
);

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_killed;
  logic [7:0]  r_wait;
  logic        r_valid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_timeout;

  logic        w_req;
  logic        w_legal;
  logic        w_timeout;
  logic        w_drop_load;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_req     = en & mem_request_type_in & ~kill_in & (r_state == ST_IDLE);
  assign w_legal   = access_legal(mem_request_write_in, funct3_in, addr_in[1:0]);
  assign w_timeout = ~dmem.ready & (r_wait == 8'(MAX_WAIT - 1));
  // A kill seen in any ACCESS cycle, including the completing one, discards the load
  assign w_drop_load = r_write | r_killed | kill_in;

  // Gated by rst_n so every output reads 0 while reset is held
  assign stall_out        = rst_n & ((r_state == ST_ACCESS) | (w_req & w_legal));
  assign access_fault_out = rst_n & w_req & ~w_legal;

  assign load_data_out  = r_load_data;
  assign load_valid_out = r_load_valid;
  assign timeout_out    = r_timeout;
  assign dmem.valid     = r_valid;
  assign dmem.write     = r_write;
  assign dmem.addr      = r_addr;
  assign dmem.wdata     = r_wdata;
  assign dmem.wstrb     = r_wstrb;

  // Lane placement of store data and byte strobes for the incoming request
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (mem_request_write_in) begin
      case (funct3_in)
        F3_SB: begin
          w_wstrb = 4'b0001 << addr_in[1:0];
          w_wdata = {4{store_data_in[7:0]}};
        end
        F3_SH: begin
          w_wstrb = 4'b0011 << {addr_in[1], 1'b0};
          w_wdata = {2{store_data_in[15:0]}};
        end
        F3_SW: begin
          w_wstrb = 4'b1111;
          w_wdata = store_data_in;
        end
        default: ;
      endcase
    end
  end

  mem_access_unit_load_extend u_load_extend (
    .rdata   (dmem.rdata),
    .addr_lo (r_addr_lo),
    .funct3  (r_funct3),
    .data    (w_ext)
  );

  // Access FSM with registered bus outputs, load result and sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_killed     <= 1'b0;
      r_wait       <= 8'h00;
      r_valid      <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'b0000;
      r_load_data  <= 32'h0;
      r_load_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req && w_legal) begin
            r_write   <= mem_request_write_in;
            r_funct3  <= funct3_in;
            r_addr_lo <= addr_in[1:0];
            r_addr    <= {addr_in[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_valid   <= 1'b1;
            r_wait    <= 8'h00;
            r_killed  <= 1'b0;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (kill_in) r_killed <= 1'b1;
          if (dmem.ready) begin
            r_valid <= 1'b0;
            if (!w_drop_load) begin
              r_load_data  <= w_ext;
              r_load_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b1;
            if (!w_drop_load) begin
              r_load_data  <= 32'h0;
              r_load_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
